// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronizes and deglitches the PS/2 clock,
// samples data on filtered falling edges, checks odd parity and stop bit.
module ps2_frame_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk_100mhz,
    input  logic       rst,
    input  logic       kbd_clk,
    input  logic       kbd_data,
    output logic [7:0] data,
    output logic       done,
    output logic       err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_s, dat_s;

    logic                   filt_q, filt_d;
    logic [FW-1:0]          filt_cnt_q, filt_cnt_d;
    logic                   fall;

    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [TW-1:0]          tout_q, tout_d;
    logic [7:0]             data_q, data_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], kbd_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], kbd_data};
    end

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];

    // The filtered clock flips only once FILTER_LEN samples in a row disagree with it.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
    end

    assign fall = filt_q & ~filt_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tout_d    = tout_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tout_d    = '0;
                bit_cnt_d = 3'd0;
                if (fall && !dat_s) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d = {dat_s, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        state_d   = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_d   = dat_s;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    if (dat_s && (^{shift_q, par_q})) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A sample event in the same cycle as the timeout keeps the frame alive.
        if (state_q != ST_IDLE) begin
            if (fall) begin
                tout_d = '0;
            end else if (tout_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d   = ST_IDLE;
                bit_cnt_d = 3'd0;
                tout_d    = '0;
                err_d     = 1'b1;
            end else begin
                tout_d = tout_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            tout_q     <= '0;
            data_q     <= 8'h00;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tout_q     <= tout_d;
            data_q     <= data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign data = data_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Bench for ps2_frame_rx: bit-level PS/2 frames (scaled-up clock rate) checked
// against a frame-level parity/stop model.
module tb_ps2_frame_rx;

    localparam int SYNC    = 2;
    localparam int FILT    = 8;
    localparam int TIMEOUT = 1500;
    localparam int HALF    = 30;
    localparam int LAT     = SYNC + FILT;

    logic       clk = 1'b0;
    logic       rst;
    logic       kbd_clk;
    logic       kbd_data;
    logic [7:0] data;
    logic       done;
    logic       err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int overlap_cnt = 0;
    int done_cyc = 0;
    int err_cyc = 0;
    int last_fall = 0;
    logic [7:0] exp_data;
    logic [7:0] got_q[$];

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC),
        .FILTER_LEN    (FILT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_100mhz(clk),
        .rst       (rst),
        .kbd_clk   (kbd_clk),
        .kbd_data  (kbd_data),
        .data      (data),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            got_q.push_back(data);
        end
        if (err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (done && err) overlap_cnt <= overlap_cnt + 1;
    end

    initial begin
        #(900000 * 10);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic p, input logic s);
        return {s, p, b, 1'b0};
    endfunction

    function automatic bit frame_ok(input logic [7:0] b, input logic p, input logic s);
        int ones;
        ones = $countones({b, p});
        return (ones % 2 == 1) && (s == 1'b1);
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the first nbits bits of a frame; glitch_idx inserts a 3-cycle low
    // pulse into the high phase following that bit's falling edge.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_idx);
        for (int i = 0; i < nbits; i++) begin
            kbd_data = bits[i];
            wait_cycles(HALF / 2);
            kbd_clk   = 1'b0;
            last_fall = cyc;
            wait_cycles(HALF);
            kbd_clk = 1'b1;
            if (i == glitch_idx) begin
                wait_cycles(HALF / 2);
                kbd_clk = 1'b0;
                wait_cycles(3);
                kbd_clk = 1'b1;
            end
            wait_cycles(HALF / 2);
        end
        kbd_data = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        kbd_clk = 1'b1;
        kbd_data = 1'b1;
        exp_data = 8'h00;
        wait_cycles(5);
        tests++;
        if (data !== 8'h00) begin fails++; $display("FAIL reset_data: got %0h expected 00", data); end
        tests++;
        if (done !== 1'b0 || err !== 1'b0) begin
            fails++; $display("FAIL reset_pulses: got done=%0b err=%0b expected 0 0", done, err);
        end
        rst = 1'b0;
        wait_cycles(50);
        tests++;
        if (done_cnt !== 0 || err_cnt !== 0) begin
            fails++; $display("FAIL reset_release: got done=%0d err=%0d expected 0 0", done_cnt, err_cnt);
        end
    endtask

    task automatic test_known_frames;
        logic [7:0] tb_b[4] = '{8'h1C, 8'hF0, 8'hF0, 8'h5A};
        logic       tb_p[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       tb_s[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        int d0, e0;
        for (int k = 0; k < 4; k++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send_bits(make_frame(tb_b[k], tb_p[k], tb_s[k]), 11, -1);
            wait_cycles(5);
            if (frame_ok(tb_b[k], tb_p[k], tb_s[k])) begin
                exp_data = tb_b[k];
                tests++;
                if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
                    fails++; $display("FAIL known_good_%0d: got done=%0d err=%0d expected 1 0", k, done_cnt - d0, err_cnt - e0);
                end
                tests++;
                if (done_cyc - last_fall !== LAT) begin
                    fails++; $display("FAIL known_latency_%0d: got %0d expected %0d", k, done_cyc - last_fall, LAT);
                end
            end else begin
                tests++;
                if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin
                    fails++; $display("FAIL known_bad_%0d: got done=%0d err=%0d expected 0 1", k, done_cnt - d0, err_cnt - e0);
                end
            end
            tests++;
            if (data !== exp_data) begin
                fails++; $display("FAIL known_data_%0d: got %0h expected %0h", k, data, exp_data);
            end
        end
    endtask

    task automatic test_glitch;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        kbd_data = 1'b0;
        kbd_clk  = 1'b0;
        wait_cycles(3);
        kbd_clk = 1'b1;
        wait_cycles(HALF);
        kbd_data = 1'b1;
        send_bits(make_frame(8'h1C, 1'b0, 1'b1), 11, 4);
        wait_cycles(5);
        exp_data = 8'h1C;
        tests++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            fails++; $display("FAIL glitch_pulses: got done=%0d err=%0d expected 1 0", done_cnt - d0, err_cnt - e0);
        end
        tests++;
        if (data !== exp_data) begin fails++; $display("FAIL glitch_data: got %0h expected %0h", data, exp_data); end
    endtask

    task automatic test_timeout;
        int d0, e0, t0, budget;
        d0 = done_cnt;
        e0 = err_cnt;
        send_bits(make_frame(8'hA7, 1'b1, 1'b1), 5, -1);
        t0 = last_fall;
        budget = 0;
        while (err_cnt == e0 && budget < TIMEOUT + 200) begin
            wait_cycles(1);
            budget++;
        end
        tests++;
        if (err_cnt - e0 !== 1) begin
            fails++; $display("FAIL timeout_fired: got %0d err pulses expected 1", err_cnt - e0);
        end
        tests++;
        if (err_cyc - t0 !== TIMEOUT + LAT) begin
            fails++; $display("FAIL timeout_time: got %0d expected %0d", err_cyc - t0, TIMEOUT + LAT);
        end
        wait_cycles(TIMEOUT + 50);
        tests++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0 || data !== exp_data) begin
            fails++; $display("FAIL timeout_after: got err=%0d done=%0d data=%0h expected 1 0 %0h", err_cnt - e0, done_cnt - d0, data, exp_data);
        end
        send_bits(make_frame(8'h5A, 1'b1, 1'b1), 11, -1);
        wait_cycles(5);
        exp_data = 8'h5A;
        tests++;
        if (done_cnt - d0 !== 1 || data !== exp_data) begin
            fails++; $display("FAIL timeout_recover: got done=%0d data=%0h expected 1 %0h", done_cnt - d0, data, exp_data);
        end
    endtask

    task automatic test_reset_midframe;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_bits(make_frame(8'h3B, 1'b0, 1'b1), 6, -1);
        rst = 1'b1;
        wait_cycles(4);
        exp_data = 8'h00;
        tests++;
        if (data !== exp_data) begin fails++; $display("FAIL midrst_data: got %0h expected 00", data); end
        rst = 1'b0;
        wait_cycles(TIMEOUT + 50);
        tests++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
            fails++; $display("FAIL midrst_pulses: got done=%0d err=%0d expected 0 0", done_cnt - d0, err_cnt - e0);
        end
        send_bits(make_frame(8'h29, 1'b0, 1'b1), 11, -1);
        wait_cycles(5);
        exp_data = 8'h29;
        tests++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0 || data !== exp_data) begin
            fails++; $display("FAIL midrst_next: got done=%0d err=%0d data=%0h expected 1 0 29", done_cnt - d0, err_cnt - e0, data);
        end
    endtask

    task automatic test_random;
        logic [7:0] b;
        logic p, s;
        int kind, d0, e0;
        for (int n = 0; n < 20; n++) begin
            b = 8'($urandom);
            kind = $urandom_range(0, 3);
            p = (kind == 0) ? (^b) : ~(^b);
            s = (kind == 1) ? 1'b0 : 1'b1;
            d0 = done_cnt;
            e0 = err_cnt;
            send_bits(make_frame(b, p, s), 11, -1);
            wait_cycles(5);
            if (frame_ok(b, p, s)) exp_data = b;
            tests++;
            if (done_cnt - d0 !== (frame_ok(b, p, s) ? 1 : 0) ||
                err_cnt - e0 !== (frame_ok(b, p, s) ? 0 : 1) || data !== exp_data) begin
                fails++;
                $display("FAIL random_%0d: byte %0h p=%0b s=%0b got done=%0d err=%0d data=%0h expected data %0h",
                         n, b, p, s, done_cnt - d0, err_cnt - e0, data, exp_data);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        got_q.delete();
        for (int n = 0; n < 5; n++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_bits(make_frame(b, ~(^b), 1'b1), 11, -1);
        end
        wait_cycles(5);
        exp_data = exp_q[$];
        tests++;
        if (got_q.size() !== exp_q.size()) begin
            fails++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int n = 0; n < exp_q.size(); n++) begin
                tests++;
                if (got_q[n] !== exp_q[n]) begin
                    fails++; $display("FAIL b2b_data_%0d: got %0h expected %0h", n, got_q[n], exp_q[n]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_frames();
        test_glitch();
        test_timeout();
        test_reset_midframe();
        test_random();
        test_back_to_back();
        tests++;
        if (overlap_cnt !== 0) begin
            fails++; $display("FAIL done_err_overlap: got %0d cycles expected 0", overlap_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_frame_rx.md
PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flops per asynchronous input, minimum 2.
REQ-002 Parameter FILTER_LEN, default 8: consecutive identical synchronized samples required before filtered kbd_clk changes level.
REQ-003 Parameter TIMEOUT_CYCLES, default 200000: maximum idle cycles allowed between falling edges inside a frame (2 ms at 100 MHz).
REQ-004 clk_100mhz  input  1  sole clock, 100 MHz.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 kbd_clk  input  1  raw PS/2 clock pin, asynchronous to clk_100mhz.
REQ-007 kbd_data  input  1  raw PS/2 data pin, asynchronous to clk_100mhz.
REQ-008 data  output  8  last correctly received byte; holds between frames.
REQ-009 done  output  1  one-cycle pulse: data has just been updated with a valid byte.
REQ-010 err  output  1  one-cycle pulse: frame aborted (parity, stop-bit or timeout fault).

Function
REQ-011 kbd_clk and kbd_data each SHALL pass through SYNC_STAGES flops before any use.
REQ-012 Filtered clock SHALL change level only after FILTER_LEN consecutive synchronized samples differ from its current level; any shorter run SHALL be ignored.
REQ-013 A sample event SHALL occur in the cycle where filtered clock goes 1->0; kbd_data SHALL be taken from the synchronized data line in that same cycle.
REQ-014 State machine SHALL have states IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: sample of 0 -> DATA with bit count 0; sample of 1 -> stay IDLE, no pulse.
REQ-016 DATA: bits SHALL shift in LSB first; after the 8th bit (count 7) -> PARITY.
REQ-017 PARITY: sample SHALL be recorded; parity is good when the 8 data bits plus parity bit contain an odd number of ones; -> STOP.
REQ-018 STOP: on sample, -> IDLE; if stop bit = 1 and parity good, data <= shifted byte and done = 1 in the next cycle; otherwise err = 1 in the next cycle and data SHALL be unchanged.
REQ-019 A 3-bit counter SHALL count data bits; it SHALL not wrap outside DATA.
REQ-020 In DATA, PARITY or STOP, a counter SHALL count cycles since the last sample event and clear on each event; on reaching TIMEOUT_CYCLES -> IDLE, err = 1 for one cycle, data unchanged.
REQ-021 Timeout counter SHALL be held at 0 in IDLE; no timeout SHALL be reported from IDLE.
REQ-022 done and err SHALL never be high in the same cycle; each SHALL be high for at most one cycle per frame.
REQ-023 If a timeout and a sample event coincide, the sample event SHALL win and the timeout SHALL not fire.
REQ-024 Back-to-back frames SHALL be accepted with no dead time beyond the stop-bit sample.

Reset
REQ-025 While rst = 1: data = 0x00, done = 0, err = 0, state IDLE, bit count 0, timeout count 0.
REQ-026 During reset, synchronizer flops and filtered clock SHALL be set to 1 (idle bus) so release does not create a false falling edge.
REQ-027 rst asserted mid-frame SHALL discard the partial frame with no done or err pulse; reception SHALL restart at the next start bit after release.

Verification
REQ-028 Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz PS/2 clock -> data = 0x1C, single done pulse one cycle after stop-bit edge, err stays 0.
REQ-029 Frame 0xF0 with parity 0 (bad) -> one err pulse, no done, data keeps previous 0x1C; following valid 0xF0 with parity 1 -> data = 0xF0, done pulse.
REQ-030 Valid 0x5A byte and parity with stop bit 0 -> one err pulse, data unchanged.
REQ-031 3-cycle low glitch on kbd_clk at idle and inside a frame (FILTER_LEN = 8) -> no sample counted; frame 0x1C still received correctly.
REQ-032 Frame stopped after 4 data bits, bus idle for TIMEOUT_CYCLES -> single err pulse exactly TIMEOUT_CYCLES after last edge, state IDLE; next frame 0x5A -> data = 0x5A, done pulse.
REQ-033 rst pulsed after 5 data bits of a frame -> data = 0x00, no pulses; next full frame 0x29 -> data = 0x29, done pulse.
